// File: rtl/retire_stage.sv
// Retire stage: commits up to three ROB entries per cycle, raises the mispredict flush and
// tracks halt. Performance counters are built only when RETIRE_PERF_CNT_EN is defined.

package retire_pkg;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned ROB_PRF_W  = 6;
    localparam int unsigned ROB_ARCH_W = 5;

    typedef struct packed {
        logic                  valid;
        logic                  halt;
        logic                  is_store;
        logic                  precise_state_need;
        logic [XLEN-1:0]       target_pc;
        logic [ROB_ARCH_W-1:0] arch_reg;
        logic [ROB_PRF_W-1:0]  Tag;
        logic [ROB_PRF_W-1:0]  Told;
    } ROB_ENTRY_PACKET;
endpackage

module retire_stage #(
    parameter int unsigned PRF_W          = retire_pkg::ROB_PRF_W,
    parameter int unsigned ARCH_W         = retire_pkg::ROB_ARCH_W,
    parameter int unsigned RECOVER_CYCLES = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  retire_pkg::ROB_ENTRY_PACKET [2:0]     retire_entry,
    output logic [2:0]                            map_ar_valid,
    output logic [2:0][ARCH_W-1:0]                map_ar,
    output logic [2:0][PRF_W-1:0]                 map_tag,
    output logic [2:0]                            fl_free_valid,
    output logic [2:0][PRF_W-1:0]                 fl_free_tag,
    output logic [2:0]                            sq_retire,
    output logic                                  BPRecoverEN,
    output logic [retire_pkg::XLEN-1:0]           recover_pc,
    output logic                                  halt,
    output logic [CNT_W-1:0]                      retire_count,
    output logic [CNT_W-1:0]                      mispredict_count
);

    localparam logic [1:0] ST_NORMAL  = 2'd0;
    localparam logic [1:0] ST_RECOVER = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    localparam logic [2:0] RC_LAST = 3'(RECOVER_CYCLES - 1);

    logic [1:0]                  state_q, state_d;
    logic [2:0]                  rc_q, rc_d;
    logic                        bp_q, bp_d;
    logic [retire_pkg::XLEN-1:0] pc_q, pc_d;
    logic                        halt_q, halt_d;

    logic [2:0]                  eligible;
    logic                        term_mis;
    logic                        term_halt;
    logic [retire_pkg::XLEN-1:0] term_pc;

    // Oldest-first scan; the chain breaks on the first invalid slot or after a terminator.
    always_comb begin : scan
        logic live;
        live      = (state_q == ST_NORMAL);
        eligible  = '0;
        term_mis  = 1'b0;
        term_halt = 1'b0;
        term_pc   = '0;
        for (int i = 2; i >= 0; i--) begin
            if (live && retire_entry[i].valid) begin
                eligible[i] = 1'b1;
                if (retire_entry[i].halt || retire_entry[i].precise_state_need) begin
                    live      = 1'b0;
                    term_halt = retire_entry[i].halt;
                    term_mis  = retire_entry[i].precise_state_need & ~retire_entry[i].halt;
                    term_pc   = retire_entry[i].target_pc;
                end
            end else begin
                live = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            map_ar_valid[i]  = eligible[i] && (retire_entry[i].arch_reg != '0);
            fl_free_valid[i] = map_ar_valid[i];
            map_ar[i]        = map_ar_valid[i] ? retire_entry[i].arch_reg : '0;
            map_tag[i]       = map_ar_valid[i] ? retire_entry[i].Tag : '0;
            fl_free_tag[i]   = map_ar_valid[i] ? retire_entry[i].Told : '0;
            sq_retire[i]     = eligible[i] && retire_entry[i].is_store;
        end
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        bp_d    = 1'b0;
        pc_d    = '0;
        halt_d  = halt_q;
        case (state_q)
            ST_NORMAL: begin
                if (term_mis) begin
                    state_d = ST_RECOVER;
                    rc_d    = '0;
                    bp_d    = 1'b1;
                    pc_d    = term_pc;
                end else if (term_halt) begin
                    state_d = ST_HALTED;
                    halt_d  = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (rc_q == RC_LAST) begin
                    state_d = ST_NORMAL;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q + 3'd1;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_NORMAL;
            rc_q    <= '0;
            bp_q    <= 1'b0;
            pc_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            bp_q    <= bp_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
        end
    end

    assign BPRecoverEN = bp_q;
    assign recover_pc  = pc_q;
    assign halt        = halt_q;

`ifdef RETIRE_PERF_CNT_EN
    logic [CNT_W-1:0] ret_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;
    logic [CNT_W-1:0] n_retired;

    assign n_retired = CNT_W'(eligible[2]) + CNT_W'(eligible[1]) + CNT_W'(eligible[0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            ret_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            ret_cnt_q <= ret_cnt_q + n_retired;
            if (term_mis) begin
                mis_cnt_q <= mis_cnt_q + 1'b1;
            end
        end
    end

    assign retire_count     = ret_cnt_q;
    assign mispredict_count = mis_cnt_q;
`else
    assign retire_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Randomized self-checking bench for retire_stage against a slot-list reference model.
module tb_retire_stage;
    import retire_pkg::*;

    localparam int unsigned PW = retire_pkg::ROB_PRF_W;
    localparam int unsigned AW = retire_pkg::ROB_ARCH_W;
    localparam int unsigned RC = 3;

    logic                       clock = 1'b0;
    logic                       reset;
    ROB_ENTRY_PACKET [2:0]      retire_entry;
    logic [2:0]                 map_ar_valid;
    logic [2:0][AW-1:0]         map_ar;
    logic [2:0][PW-1:0]         map_tag;
    logic [2:0]                 fl_free_valid;
    logic [2:0][PW-1:0]         fl_free_tag;
    logic [2:0]                 sq_retire;
    logic                       BPRecoverEN;
    logic [XLEN-1:0]            recover_pc;
    logic                       halt;
    logic [31:0]                retire_count;
    logic [31:0]                mispredict_count;

    retire_stage #(
        .PRF_W          (PW),
        .ARCH_W         (AW),
        .RECOVER_CYCLES (RC),
        .CNT_W          (32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .retire_entry     (retire_entry),
        .map_ar_valid     (map_ar_valid),
        .map_ar           (map_ar),
        .map_tag          (map_tag),
        .fl_free_valid    (fl_free_valid),
        .fl_free_tag      (fl_free_tag),
        .sq_retire        (sq_retire),
        .BPRecoverEN      (BPRecoverEN),
        .recover_pc       (recover_pc),
        .halt             (halt),
        .retire_count     (retire_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: cycles left in recovery, halted flag, registered flush, totals.
    int              m_rec_left = 0;
    bit              m_halted   = 0;
    bit              m_bp       = 0;
    logic [XLEN-1:0] m_pc       = '0;
    longint          m_ret      = 0;
    longint          m_mis      = 0;

    logic [2:0]          e_mav, e_fv, e_sq;
    logic [2:0][AW-1:0]  e_ar;
    logic [2:0][PW-1:0]  e_tag, e_told;
    int                  e_n;
    int                  e_term;  // 0 none, 1 mispredict, 2 halt
    logic [XLEN-1:0]     e_tpc;

    function automatic void model_outputs();
        e_mav = '0; e_fv = '0; e_sq = '0; e_ar = '0; e_tag = '0; e_told = '0;
        e_n = 0; e_term = 0; e_tpc = '0;
        if (m_halted || m_rec_left != 0) return;
        for (int s = 2; s >= 0; s--) begin
            if (!retire_entry[s].valid) break;
            e_n++;
            e_sq[s] = retire_entry[s].is_store;
            if (retire_entry[s].arch_reg != 0) begin
                e_mav[s]  = 1'b1;
                e_fv[s]   = 1'b1;
                e_ar[s]   = retire_entry[s].arch_reg;
                e_tag[s]  = retire_entry[s].Tag;
                e_told[s] = retire_entry[s].Told;
            end
            if (retire_entry[s].halt) begin
                e_term = 2;
                break;
            end
            if (retire_entry[s].precise_state_need) begin
                e_term = 1;
                e_tpc  = retire_entry[s].target_pc;
                break;
            end
        end
    endfunction

    function automatic void model_edge();
        model_outputs();
        if (reset) begin
            m_rec_left = 0; m_halted = 0; m_bp = 0; m_pc = '0; m_ret = 0; m_mis = 0;
        end else if (m_halted) begin
            m_bp = 0; m_pc = '0;
        end else if (m_rec_left > 0) begin
            m_rec_left--; m_bp = 0; m_pc = '0;
        end else begin
            m_ret += e_n;
            m_bp = 0; m_pc = '0;
            if (e_term == 1) begin
                m_rec_left = RC; m_bp = 1; m_pc = e_tpc; m_mis++;
            end else if (e_term == 2) begin
                m_halted = 1;
            end
        end
    endfunction

    task automatic check_all();
        model_outputs();
        check("map_ar_valid", 64'(map_ar_valid), 64'(e_mav));
        check("map_ar", 64'(map_ar), 64'(e_ar));
        check("map_tag", 64'(map_tag), 64'(e_tag));
        check("fl_free_valid", 64'(fl_free_valid), 64'(e_fv));
        check("fl_free_tag", 64'(fl_free_tag), 64'(e_told));
        check("sq_retire", 64'(sq_retire), 64'(e_sq));
        check("BPRecoverEN", 64'(BPRecoverEN), 64'(m_bp));
        check("recover_pc", 64'(recover_pc), 64'(m_pc));
        check("halt", 64'(halt), 64'(m_halted));
`ifdef RETIRE_PERF_CNT_EN
        check("retire_count", 64'(retire_count), 64'(m_ret[31:0]));
        check("mispredict_count", 64'(mispredict_count), 64'(m_mis[31:0]));
`else
        check("retire_count", 64'(retire_count), 64'd0);
        check("mispredict_count", 64'(mispredict_count), 64'd0);
`endif
    endtask

    // Check the current cycle at the falling edge, then advance model and DUT together.
    task automatic step();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    function automatic ROB_ENTRY_PACKET mk(input bit v, input bit h, input bit st, input bit psn,
                                           input int pc, input int ar, input int tg,
                                           input int to);
        ROB_ENTRY_PACKET e;
        e.valid              = v;
        e.halt               = h;
        e.is_store           = st;
        e.precise_state_need = psn;
        e.target_pc          = XLEN'(pc);
        e.arch_reg           = AW'(ar);
        e.Tag                = PW'(tg);
        e.Told               = PW'(to);
        return e;
    endfunction

    function automatic ROB_ENTRY_PACKET rnd_entry();
        int ar;
        ar = ($urandom % 4 == 0) ? 0 : int'($urandom % 32);
        return mk(($urandom % 5) != 0, ($urandom % 48) == 0, ($urandom % 3) == 0,
                  ($urandom % 12) == 0, int'($urandom & 32'hffff_fffc), ar,
                  int'($urandom % 64), int'($urandom % 64));
    endfunction

    localparam ROB_ENTRY_PACKET NOP = '0;

    initial begin
        reset        = 1'b1;
        retire_entry = '{NOP, NOP, NOP};
        @(posedge clock);
        model_edge();
        #1;
        step();  // reset state visible, reset still high
        reset = 1'b0;

        // Three plain retirements.
        retire_entry[2] = mk(1, 0, 0, 0, 0, 3, 10, 20);
        retire_entry[1] = mk(1, 0, 0, 0, 0, 4, 11, 21);
        retire_entry[0] = mk(1, 0, 0, 0, 0, 5, 12, 22);
        step();

        // x0 destination, then a store, then invalid slot with a valid-looking younger gap.
        retire_entry[2] = mk(1, 0, 0, 0, 0, 0, 7, 8);
        retire_entry[1] = mk(1, 0, 1, 0, 0, 0, 9, 9);
        retire_entry[0] = NOP;
        step();

        // Mispredict in slot 1 suppresses the younger store; flush follows one cycle later.
        retire_entry[2] = mk(1, 0, 0, 0, 0, 6, 1, 2);
        retire_entry[1] = mk(1, 0, 0, 1, 32'h100, 7, 3, 4);
        retire_entry[0] = mk(1, 0, 1, 0, 0, 8, 5, 6);
        step();
        for (int k = 0; k < RC + 1; k++) step();

        // Invalid older slot hides a valid younger slot.
        retire_entry[2] = mk(1, 0, 0, 0, 0, 9, 1, 1);
        retire_entry[1] = NOP;
        retire_entry[0] = mk(1, 0, 1, 0, 0, 9, 2, 2);
        step();

        // Reset in the middle of recovery.
        retire_entry[2] = mk(1, 0, 0, 1, 32'h2000, 1, 1, 1);
        retire_entry[1] = NOP;
        retire_entry[0] = NOP;
        step();
        reset        = 1'b1;
        retire_entry = '{NOP, NOP, NOP};
        step();
        reset = 1'b0;
        step();
        step();
        retire_entry[2] = mk(1, 0, 1, 0, 0, 12, 13, 14);
        step();

        // Halt older than a mispredict: halt wins, input ignored afterwards.
        retire_entry[2] = mk(1, 1, 0, 0, 0, 2, 3, 4);
        retire_entry[1] = mk(1, 0, 0, 1, 32'h300, 3, 4, 5);
        retire_entry[0] = mk(1, 0, 1, 0, 0, 4, 5, 6);
        step();
        retire_entry[2] = mk(1, 0, 1, 0, 0, 2, 3, 4);
        retire_entry[1] = mk(1, 0, 1, 0, 0, 3, 4, 5);
        retire_entry[0] = mk(1, 0, 1, 0, 0, 4, 5, 6);
        for (int k = 0; k < 3; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            reset           = m_halted ? (($urandom % 6) == 0) : (($urandom % 60) == 0);
            retire_entry[2] = rnd_entry();
            retire_entry[1] = rnd_entry();
            retire_entry[0] = rnd_entry();
            step();
        end
        reset = 1'b0;
        retire_entry = '{NOP, NOP, NOP};
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- Consumer of the ROB retire interface: takes up to 3 retiring entries per cycle, oldest in slot 2.
- Commits architectural state: arch map table writes, free-list returns of Told, and store-queue commit strobes.
- Detects the oldest retiring mispredict and drives the registered BPRecoverEN flush plus the fetch redirect PC.
- Detects halt and keeps retire and performance counters.

Parameters:
- PRF_W, 6, physical register tag width.
- ARCH_W, 5, architectural register index width.
- RECOVER_CYCLES, 1, cycles spent in RECOVER (min 1, max 7).
- CNT_W, 32, width of the performance counters.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- retire_entry  in  ROB_ENTRY_PACKET[2:0]  from ROB. Slot 2 is oldest. Fields used: valid, halt, is_store, precise_state_need, target_pc, arch_reg, Tag, Told.
- map_ar_valid  out  3  arch map write enable per slot.
- map_ar  out  3xARCH_W  arch register index per slot.
- map_tag  out  3xPRF_W  new tag per slot.
- fl_free_valid  out  3  free-list return enable per slot.
- fl_free_tag  out  3xPRF_W  Told returned per slot.
- sq_retire  out  3  store commit strobe per slot.
- BPRecoverEN  out  1  registered flush to ROB, RS, map table and fetch.
- recover_pc  out  XLEN  registered redirect PC, valid while BPRecoverEN=1.
- halt  out  1  sticky halt.
- retire_count  out  CNT_W  instructions retired.
- mispredict_count  out  CNT_W  recoveries taken.

Behaviour:
- Reset values: every output is 0; state=NORMAL; recover counter 0.
- Slot scan runs combinationally in order 2, 1, 0, in NORMAL state only.
  - A slot is eligible if its own valid=1 and every older slot was eligible and not a terminator.
  - A slot after the first invalid slot is ignored, even if its valid=1.
  - Terminator: precise_state_need=1 or halt=1. The terminator itself retires. All younger slots are suppressed (no map, free-list or store strobes).
- Per eligible slot, same cycle:
  - If arch_reg!=0: map_ar_valid=1 and fl_free_valid=1, with map_ar=arch_reg, map_tag=Tag, fl_free_tag=Told.
  - If arch_reg==0: map_ar_valid=0 and fl_free_valid=0.
  - sq_retire=is_store.
- Per-slot outputs are 0 for non-eligible slots and in every state other than NORMAL.
- FSM states:
  - NORMAL: terminator is precise_state_need -> RECOVER. Halt terminator -> HALTED. Otherwise stay.
  - RECOVER: BPRecoverEN=1 during the first RECOVER cycle only. recover_pc holds the registered target_pc of the terminating slot. Input is ignored for all RECOVER_CYCLES cycles, then -> NORMAL. BPRecoverEN and recover_pc return to 0 on leaving the first RECOVER cycle.
  - HALTED: halt=1 from the cycle after the halt retires until reset. All input is ignored.
- Latency:
  - Per-slot commit outputs: 0 cycles, combinational from retire_entry.
  - BPRecoverEN: exactly 1 cycle after the mispredicting branch is presented.
- Simultaneous halt and mispredict in one group: the older slot wins. The younger one is suppressed.
- Counters:
  - retire_count adds the number of eligible slots (0-3) each NORMAL cycle and wraps modulo 2^CNT_W.
  - mispredict_count increments on entry to RECOVER.
- Reset during RECOVER or HALTED: back to NORMAL next cycle; BPRecoverEN=0 and halt=0.

Optional Feature:
- Macro RETIRE_PERF_CNT_EN.
- Defined: retire_count and mispredict_count behave as above.
- Undefined: no counter flops are built, and both outputs are tied to 0.
- All other behaviour is identical either way.

Test Plan:
- Three valid non-branch entries with arch_reg 3/4/5, Tag 10/11/12, Told 20/21/22 -> in the same cycle map_ar_valid=3'b111, fl_free_tag={22,21,20} in slot order 0,1,0-ordered, sq_retire=0, retire_count +3.
- Slot 2 valid with arch_reg=0, slot 1 a store, slot 0 invalid -> map_ar_valid=3'b000, fl_free_valid=3'b000, sq_retire=3'b010, retire_count +2.
- Slot 1 has precise_state_need=1 with target_pc=0x100, slot 0 a valid store -> slot 0 suppressed (sq_retire[0]=0). Next cycle BPRecoverEN=1 and recover_pc=0x100, with input ignored. The cycle after, BPRecoverEN=0 and state is NORMAL. mispredict_count=1.
- Slot 2 halt, slot 1 mispredict -> halt=1 the next cycle and stays high, BPRecoverEN never asserts, later valid input produces no strobes.
- Assert reset during the RECOVER cycle with RECOVER_CYCLES=3 -> all outputs 0 next cycle, and a valid entry two cycles later retires normally.
- Build without RETIRE_PERF_CNT_EN and rerun the first scenario -> retire_count stays 0, and all other outputs are unchanged.
